// File: rtl/arf_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : arf_pkg
//  Purpose  : Shared constants for the parametrised address register file:
//             funsel operation codes and the default register indices
//             (AR, SP, PCPREV, PC).
//  Macros   : ARF_SAT_EN (used by arf_cell; nothing here depends on it)
//  Revision : 1.0 - initial release
// ============================================================================
package arf_pkg;

    // funsel operation codes
    localparam logic [1:0] FS_CLEAR = 2'b00;
    localparam logic [1:0] FS_LOAD  = 2'b01;
    localparam logic [1:0] FS_DEC   = 2'b10;
    localparam logic [1:0] FS_INC   = 2'b11;

    // Default register indices of the classic 4-register layout
    localparam int ARF_AR_IDX     = 0;
    localparam int ARF_SP_IDX     = 1;
    localparam int ARF_PCPREV_IDX = 2;
    localparam int ARF_PC_IDX     = 3;

endpackage : arf_pkg
`default_nettype wire

// File: rtl/arf_cell.sv
`default_nettype none
// ============================================================================
//  Module   : arf_cell
//  Purpose  : One address register with its sticky wrap/saturation flag.
//             Performs clear / load / decrement / increment when selected;
//             otherwise optionally captures history data (PCPREV use).
//  Ports    : clk, rst          - clock, async active-high reset
//             we_i              - this register is selected for the op
//             funsel_i, step_i  - operation and inc/dec amount
//             load_i            - load data
//             cap_en_i, cap_data_i - history capture (only when not selected)
//             value_o, flag_o   - register value and sticky flag
//  Macros   : ARF_SAT_EN - inc/dec saturate instead of wrapping
//  Revision : 1.0 - initial release
// ============================================================================
module arf_cell
    import arf_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [1:0]        funsel_i,
    input  logic [STEP_W-1:0] step_i,
    input  logic [WIDTH-1:0]  load_i,
    input  logic              cap_en_i,
    input  logic [WIDTH-1:0]  cap_data_i,
    output logic [WIDTH-1:0]  value_o,
    output logic              flag_o
);

    // Arithmetic is done one bit wider than the larger operand so the true
    // (unwrapped) result is visible for overflow/underflow detection.
    localparam int EW = ((WIDTH > STEP_W) ? WIDTH : STEP_W) + 1;

    logic [WIDTH-1:0] value_q, value_d;
    logic             flag_q,  flag_d;

    logic [EW-1:0]    w_val_ext, w_step_ext, w_sum, w_diff;
    logic             w_ovf, w_unf;
    logic [WIDTH-1:0] w_inc_res, w_dec_res;

    assign w_val_ext  = EW'(value_q);
    assign w_step_ext = EW'(step_i);
    assign w_sum      = w_val_ext + w_step_ext;
    assign w_diff     = w_val_ext - w_step_ext;
    assign w_ovf      = |w_sum[EW-1:WIDTH];
    assign w_unf      = (w_step_ext > w_val_ext);

`ifdef ARF_SAT_EN
    assign w_inc_res = w_ovf ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
    assign w_dec_res = w_unf ? {WIDTH{1'b0}} : w_diff[WIDTH-1:0];
`else
    assign w_inc_res = w_sum[WIDTH-1:0];
    assign w_dec_res = w_diff[WIDTH-1:0];
`endif

    always_comb begin
        value_d = value_q;
        flag_d  = flag_q;
        if (we_i) begin
            case (funsel_i)
                FS_CLEAR: begin
                    value_d = '0;
                    flag_d  = 1'b0;
                end
                FS_LOAD: value_d = load_i;
                FS_DEC: begin
                    value_d = w_dec_res;
                    flag_d  = flag_q | w_unf;
                end
                FS_INC: begin
                    value_d = w_inc_res;
                    flag_d  = flag_q | w_ovf;
                end
                default: ;
            endcase
        end else if (cap_en_i) begin
            // An explicit op on this register always beats history capture.
            value_d = cap_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= '0;
            flag_q  <= 1'b0;
        end else begin
            value_q <= value_d;
            flag_q  <= flag_d;
        end
    end

    assign value_o = value_q;
    assign flag_o  = flag_q;

endmodule : arf_cell
`default_nettype wire

// File: rtl/addr_reg_file_p.sv
`default_nettype none
// ============================================================================
//  Module   : addr_reg_file_p
//  Purpose  : Parametrised address register file (AR/SP/PCPREV/PC style)
//             with variable inc/dec step, sticky per-register wrap flags,
//             automatic PC -> PCPREV history capture and two combinational
//             read ports.
//  Ports    : clk, rst            - clock, async active-high reset
//             i                   - load data
//             funsel              - 00 clear, 01 load, 10 dec, 11 inc
//             step                - inc/dec amount
//             r_sel               - write mask, bit NREGS-1-k selects reg k
//             out_a_sel/out_b_sel - read selects (>= NREGS reads 0)
//             out_a/out_b         - read data
//             wrap_flag           - sticky flags, bit k = register k
//  Macros   : ARF_SAT_EN - inc/dec saturate instead of wrapping
//  Revision : 1.0 - initial release
// ============================================================================
module addr_reg_file_p
    import arf_pkg::*;
#(
    parameter int  WIDTH      = 16,
    parameter int  NREGS      = 4,
    parameter int  STEP_W     = 4,
    parameter int  PC_IDX     = ARF_PC_IDX,
    parameter int  PCPREV_IDX = ARF_PCPREV_IDX,
    localparam int SEL_W      = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  i,
    input  logic [1:0]        funsel,
    input  logic [STEP_W-1:0] step,
    input  logic [NREGS-1:0]  r_sel,
    input  logic [SEL_W-1:0]  out_a_sel,
    input  logic [SEL_W-1:0]  out_b_sel,
    output logic [WIDTH-1:0]  out_a,
    output logic [WIDTH-1:0]  out_b,
    output logic [NREGS-1:0]  wrap_flag
);

    logic [WIDTH-1:0] w_regs [NREGS];
    logic [NREGS-1:0] w_we;
    logic             w_cap_en;

    // r_sel is MSB-first: bit NREGS-1 addresses register 0.
    always_comb begin
        w_we = '0;
        for (int k = 0; k < NREGS; k++) begin
            w_we[k] = r_sel[NREGS-1-k];
        end
    end

    // Any write to PC records its pre-edge value into PCPREV, unless PCPREV
    // is itself being written explicitly in the same cycle.
    assign w_cap_en = w_we[PC_IDX] & ~w_we[PCPREV_IDX];

    generate
        for (genvar k = 0; k < NREGS; k++) begin : g_cell
            localparam bit IS_PCPREV = (k == PCPREV_IDX);
            arf_cell #(
                .WIDTH  (WIDTH),
                .STEP_W (STEP_W)
            ) u_cell (
                .clk        (clk),
                .rst        (rst),
                .we_i       (w_we[k]),
                .funsel_i   (funsel),
                .step_i     (step),
                .load_i     (i),
                .cap_en_i   (IS_PCPREV ? w_cap_en : 1'b0),
                .cap_data_i (w_regs[PC_IDX]),
                .value_o    (w_regs[k]),
                .flag_o     (wrap_flag[k])
            );
        end
    endgenerate

    // Read muxes: a select matching no register yields zero.
    always_comb begin
        out_a = '0;
        out_b = '0;
        for (int k = 0; k < NREGS; k++) begin
            if (out_a_sel == SEL_W'(k)) out_a = w_regs[k];
            if (out_b_sel == SEL_W'(k)) out_b = w_regs[k];
        end
    end

endmodule : addr_reg_file_p
`default_nettype wire

// File: tb/tb_addr_reg_file_p.sv
`timescale 1ns/100ps
`default_nettype none
// ============================================================================
//  Module   : tb_addr_reg_file_p
//  Purpose  : Self-checking bench for addr_reg_file_p (WIDTH=8, NREGS=4,
//             STEP_W=4, default indices). Directed vectors, a behavioural
//             register-file model, and literal expectations.
//  Macros   : ARF_SAT_EN - selects the saturating expectations
//  Revision : 1.0 - initial release
// ============================================================================
module tb_addr_reg_file_p;

`ifdef ARF_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam int PC  = 3;
    localparam int PP  = 2;
    localparam int OVF_V = SAT ? 255 : 0;   // 0xFF + 1
    localparam int DEC2  = SAT ? 0 : 255;   // 0x02 - 3

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] i = '0;
    logic [1:0] funsel = '0;
    logic [3:0] step = '0;
    logic [3:0] r_sel = '0;
    logic [1:0] out_a_sel = '0;
    logic [1:0] out_b_sel = '0;
    logic [7:0] out_a, out_b;
    logic [3:0] wrap_flag;

    int errors = 0;
    int checks = 0;
    int mv [4];
    bit mf [4];
    bit check_en = 1'b0;

    addr_reg_file_p #(.WIDTH(8), .NREGS(4), .STEP_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .i         (i),
        .funsel    (funsel),
        .step      (step),
        .r_sel     (r_sel),
        .out_a_sel (out_a_sel),
        .out_b_sel (out_b_sel),
        .out_a     (out_a),
        .out_b     (out_b),
        .wrap_flag (wrap_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] model_flags();
        logic [3:0] f;
        for (int k = 0; k < 4; k++) f[k] = mf[k];
        return f;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            mv[k] = 0;
            mf[k] = 1'b0;
        end
    endtask

    // Register-file semantics in plain integer arithmetic.
    task automatic model_step(input logic [1:0] fs, input int st, input logic [3:0] rs, input int din);
        int old [4];
        int t;
        for (int k = 0; k < 4; k++) old[k] = mv[k];
        for (int k = 0; k < 4; k++) begin
            if (rs[3-k]) begin
                case (fs)
                    2'd0: begin mv[k] = 0; mf[k] = 1'b0; end
                    2'd1: mv[k] = din;
                    2'd2: begin
                        t = old[k] - st;
                        if (t < 0) begin mf[k] = 1'b1; mv[k] = SAT ? 0 : t + 256; end
                        else mv[k] = t;
                    end
                    default: begin
                        t = old[k] + st;
                        if (t > 255) begin mf[k] = 1'b1; mv[k] = SAT ? 255 : t - 256; end
                        else mv[k] = t;
                    end
                endcase
            end
        end
        if (rs[3-PC] && !rs[3-PP]) mv[PP] = old[PC];
    endtask

    // Continuous comparison against the model on every falling edge.
    always @(negedge clk) begin
        if (check_en && !rst) begin
            chk("cmp_out_a", out_a, mv[out_a_sel]);
            chk("cmp_out_b", out_b, mv[out_b_sel]);
            chk("cmp_flags", wrap_flag, model_flags());
        end
    end

    task automatic op(input logic [1:0] fs, input int st, input logic [3:0] rs, input int din);
        funsel = fs;
        step   = st[3:0];
        r_sel  = rs;
        i      = din[7:0];
        @(posedge clk);
        #1;
        model_step(fs, st, rs, din);
        r_sel = 4'b0000;
    endtask

    task automatic rd(input logic [1:0] sa, input logic [1:0] sb, input int ea, input int eb, input string name);
        @(posedge clk);
        #1;
        out_a_sel = sa;
        out_b_sel = sb;
        #1;
        chk({name, "_a"}, out_a, ea);
        chk({name, "_b"}, out_b, eb);
    endtask

    initial begin
        model_reset();
        #1 rst = 1'b1;
        #1;
        chk("reset_out_a", out_a, 0);
        chk("reset_out_b", out_b, 0);
        chk("reset_flags", wrap_flag, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        check_en = 1'b1;

        // Fill every register with 0xFF, overflow all, then load 0x5A
        op(2'b01, 0, 4'b1111, 8'hFF);
        op(2'b11, 1, 4'b1111, 0);
        op(2'b01, 0, 4'b1111, 8'h5A);
        rd(2'd0, 2'd3, 8'h5A, 8'h5A, "load_all");
        chk("flags_before_rst", wrap_flag, 4'hF);
        // Mid-cycle async reset
        #0.5 rst = 1'b1;
        #0.5;
        chk("rst_async_out_a", out_a, 0);
        chk("rst_async_out_b", out_b, 0);
        chk("rst_async_flags", wrap_flag, 0);
        model_reset();
        #0.5 rst = 1'b0;

        // Load and read
        op(2'b01, 0, 4'b1000, 8'h3C);
        rd(2'd0, 2'd0, 8'h3C, 8'h3C, "rd_sel0");
        rd(2'd1, 2'd1, 0, 0, "rd_sel1");
        rd(2'd2, 2'd2, 0, 0, "rd_sel2");
        rd(2'd3, 2'd3, 0, 0, "rd_sel3");

        // Overflow, step 0, clear
        op(2'b01, 0, 4'b1000, 8'hFF);
        op(2'b11, 1, 4'b1000, 0);
        rd(2'd0, 2'd1, OVF_V, 0, "overflow");
        chk("overflow_flag", wrap_flag, 4'b0001);
        op(2'b11, 0, 4'b1000, 0);
        rd(2'd0, 2'd0, OVF_V, OVF_V, "step0");
        chk("step0_flag", wrap_flag, 4'b0001);
        op(2'b00, 0, 4'b1000, 0);
        rd(2'd0, 2'd0, 0, 0, "clear");
        chk("clear_flag", wrap_flag, 4'b0000);

        // Mask decrement (reg1 and reg3; PC write captures into PCPREV)
        op(2'b01, 0, 4'b1000, 8'h11);
        op(2'b01, 0, 4'b0101, 8'h05);
        op(2'b10, 3, 4'b0101, 0);
        rd(2'd1, 2'd3, 8'h02, 8'h02, "dec1");
        rd(2'd0, 2'd2, 8'h11, 8'h05, "dec1_other");
        chk("dec1_flags", wrap_flag, 4'b0000);
        op(2'b10, 3, 4'b0101, 0);
        rd(2'd1, 2'd3, DEC2, DEC2, "dec2");
        rd(2'd0, 2'd2, 8'h11, 8'h02, "dec2_other");
        chk("dec2_flags", wrap_flag, 4'b1010);

        // PC history
        op(2'b01, 0, 4'b0001, 8'h10);
        op(2'b11, 2, 4'b0001, 0);
        rd(2'd3, 2'd2, 8'h12, 8'h10, "pc_hist");
        op(2'b01, 0, 4'b0011, 8'h77);
        rd(2'd3, 2'd2, 8'h77, 8'h77, "pc_both");

        // Idle: nothing selected
        for (int f = 0; f < 4; f++) op(f[1:0], 5, 4'b0000, 8'hAB);
        rd(2'd3, 2'd2, 8'h77, 8'h77, "idle_pc");
        rd(2'd0, 2'd1, 8'h11, DEC2, "idle_ar");
        chk("idle_flags", wrap_flag, 4'b1010);

        // Op pending on an edge coincident with reset is discarded
        funsel = 2'b01;
        r_sel  = 4'b1111;
        i      = 8'hAA;
        @(negedge clk);
        #4 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        r_sel = 4'b0000;
        model_reset();
        rd(2'd0, 2'd3, 0, 0, "rst_edge");
        chk("rst_edge_flags", wrap_flag, 0);

        // First edge after reset is a normal write
        op(2'b01, 0, 4'b1000, 8'h42);
        rd(2'd0, 2'd1, 8'h42, 0, "post_rst");

        @(negedge clk);
        #1;
        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_addr_reg_file_p
`default_nettype wire
